// File: rtl/therm_ramp_sequencer.sv
// Slew-limited level sequencer driving a registered thermometer word.
// Moves one step per (div_q+1) cycles toward an accepted target.
module therm_ramp_sequencer #(
    parameter int N     = 8,
    parameter int DIV_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tgt_valid,
    output logic               tgt_ready,
    input  logic [N-1:0]       tgt_level,
    input  logic [DIV_W-1:0]   step_div,
    input  logic               abort,
    output logic [N-1:0]       level,
    output logic [(2**N)-1:0]  therm,
    output logic               busy,
    output logic               done
);

    localparam int unsigned W = 2**N;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RAMP = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [N-1:0]     level_nxt;
    logic [N-1:0]     tgt_q, tgt_nxt;
    logic [DIV_W-1:0] div_q, div_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic             done_nxt;
    logic [W-1:0]     therm_nxt;

    assign tgt_ready = (state == IDLE);

    always_comb begin
        state_nxt = state;
        level_nxt = level;
        cnt_nxt   = cnt;
        tgt_nxt   = tgt_q;
        div_nxt   = div_q;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_nxt = tgt_level;
                    div_nxt = step_div;
                    if (tgt_level == level) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = RAMP;
                        cnt_nxt   = '0;
                    end
                end
            end
            RAMP: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == div_q) begin
                    cnt_nxt = '0;
                    // RAMP is only entered with tgt_q != level, so neither bound can be crossed
                    level_nxt = (tgt_q > level) ? level + 1'b1 : level - 1'b1;
                    if (level_nxt == tgt_q) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        therm_nxt = '0;
        for (int unsigned i = 0; i < W; i++) begin
            therm_nxt[i] = (i <= 32'(level_nxt));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            level <= '0;
            therm <= W'(1);
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            tgt_q <= '0;
            div_q <= '0;
        end else begin
            state <= state_nxt;
            level <= level_nxt;
            therm <= therm_nxt;
            busy  <= (state_nxt == RAMP);
            done  <= done_nxt;
            cnt   <= cnt_nxt;
            tgt_q <= tgt_nxt;
            div_q <= div_nxt;
        end
    end

endmodule

// File: tb/tb_therm_ramp_sequencer.sv
// Directed bench for therm_ramp_sequencer: reset, ramps, divider timing,
// equal target, abort, reset mid-ramp and full-scale sweeps.
module tb_therm_ramp_sequencer;

    logic         clk;
    logic         rst;
    logic         tgt_valid;
    logic         tgt_ready;
    logic [7:0]   tgt_level;
    logic [7:0]   step_div;
    logic         abort;
    logic [7:0]   level;
    logic [255:0] therm;
    logic         busy;
    logic         done;

    int tests;
    int fails;

    therm_ramp_sequencer #(.N(8), .DIV_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_level (tgt_level),
        .step_div  (step_div),
        .abort     (abort),
        .level     (level),
        .therm     (therm),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_therm(input string tag);
        logic [255:0] one;
        logic [255:0] sh;
        one = 256'h1;
        sh  = one << level;
        chk(tag, therm, sh | (sh - 256'h1));
    endtask

    // Handshake at the next edge, then count edges until done; every cycle checks therm.
    task automatic do_ramp(input string tag, input logic [7:0] t, input logic [7:0] dv, input int exp_n);
        int n;
        tgt_valid = 1'b1;
        tgt_level = t;
        step_div  = dv;
        tick();
        tgt_valid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            tick();
            n++;
            chk_therm({tag, "_therm"});
        end
        chk({tag, "_cycles"}, 256'(n), 256'(exp_n));
        chk({tag, "_level"}, 256'(level), 256'(t));
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b0;
        tgt_valid = 1'b0;
        tgt_level = '0;
        step_div  = '0;
        abort     = 1'b0;

        // Asynchronous reset, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_level", 256'(level), 256'h0);
        chk("rst_therm", therm, 256'h1);
        chk("rst_busy", 256'(busy), 256'h0);
        chk("rst_done", 256'(done), 256'h0);
        chk("rst_ready", 256'(tgt_ready), 256'h1);
        tick();
        tick();
        rst = 1'b0;

        // Up-ramp 0 -> 3, step_div 0
        tgt_valid = 1'b1; tgt_level = 8'd3; step_div = 8'd0;
        tick();
        tgt_valid = 1'b0;
        chk("up_e0_ready", 256'(tgt_ready), 256'h0);
        chk("up_e0_busy", 256'(busy), 256'h1);
        chk("up_e0_level", 256'(level), 256'h0);
        tick();
        chk("up_e1_level", 256'(level), 256'h1);
        chk("up_e1_done", 256'(done), 256'h0);
        chk("up_e1_busy", 256'(busy), 256'h1);
        tick();
        chk("up_e2_level", 256'(level), 256'h2);
        chk("up_e2_therm", therm, 256'h7);
        chk("up_e2_busy", 256'(busy), 256'h1);
        tick();
        chk("up_e3_level", 256'(level), 256'h3);
        chk("up_e3_done", 256'(done), 256'h1);
        chk("up_e3_therm", therm, 256'hF);
        chk("up_e3_busy", 256'(busy), 256'h0);
        chk("up_e3_ready", 256'(tgt_ready), 256'h1);
        tick();
        chk("up_e4_done", 256'(done), 256'h0);

        do_ramp("to5", 8'd5, 8'd0, 2);
        tick();

        // Down-ramp 5 -> 2, step_div 2; valid held with new values during the ramp
        tgt_valid = 1'b1; tgt_level = 8'd2; step_div = 8'd2;
        tick();
        tgt_level = 8'd9; step_div = 8'd0;
        chk("dn_e0_ready", 256'(tgt_ready), 256'h0);
        tick();
        chk("dn_e1_level", 256'(level), 256'h5);
        tick();
        chk("dn_e2_level", 256'(level), 256'h5);
        tick();
        chk("dn_e3_level", 256'(level), 256'h4);
        tick(); tick(); tick();
        chk("dn_e6_level", 256'(level), 256'h3);
        chk("dn_e6_busy", 256'(busy), 256'h1);
        tick(); tick();
        chk("dn_e8_done", 256'(done), 256'h0);
        tick();
        chk("dn_e9_level", 256'(level), 256'h2);
        chk("dn_e9_done", 256'(done), 256'h1);
        chk("dn_e9_ready", 256'(tgt_ready), 256'h1);
        chk("dn_e9_therm", therm, 256'h7);
        tick();
        tgt_valid = 1'b0;
        chk("held_acc_busy", 256'(busy), 256'h1);
        chk("held_acc_done", 256'(done), 256'h0);
        tick();
        chk("held_e1_level", 256'(level), 256'h3);
        begin
            int n;
            n = 1;
            while (done !== 1'b1 && n < 100) begin
                tick();
                n++;
            end
            chk("held_cycles", 256'(n), 256'd7);
            chk("held_level", 256'(level), 256'd9);
        end
        tick();

        // Equal target at level 7
        do_ramp("to7", 8'd7, 8'd0, 2);
        tick();
        tgt_valid = 1'b1; tgt_level = 8'd7; step_div = 8'd4;
        tick();
        tgt_valid = 1'b0;
        chk("eq_done", 256'(done), 256'h1);
        chk("eq_busy", 256'(busy), 256'h0);
        chk("eq_therm", therm, 256'hFF);
        chk("eq_level", 256'(level), 256'd7);
        tick();
        chk("eq_done_end", 256'(done), 256'h0);
        chk("eq_busy_end", 256'(busy), 256'h0);

        // Abort on a step edge: 0 -> 10, step_div 1, abort sampled at E5
        do_ramp("to0", 8'd0, 8'd0, 7);
        tick();
        tgt_valid = 1'b1; tgt_level = 8'd10; step_div = 8'd1;
        tick();
        tgt_valid = 1'b0;
        tick(); tick();
        chk("ab_e2_level", 256'(level), 256'h1);
        tick(); tick();
        chk("ab_e4_level", 256'(level), 256'h2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_e5_level", 256'(level), 256'h2);
        chk("ab_e5_busy", 256'(busy), 256'h0);
        chk("ab_e5_ready", 256'(tgt_ready), 256'h1);
        chk("ab_e5_done", 256'(done), 256'h0);
        tick();
        chk("ab_e6_done", 256'(done), 256'h0);
        chk("ab_e6_level", 256'(level), 256'h2);
        do_ramp("ab_to4", 8'd4, 8'd0, 2);
        tick();

        // Reset mid-ramp, then first edge after release accepts a request
        tgt_valid = 1'b1; tgt_level = 8'd20; step_div = 8'd0;
        tick();
        tgt_valid = 1'b0;
        tick(); tick();
        chk("mr_level", 256'(level), 256'd6);
        #2 rst = 1'b1;
        #1;
        chk("mr_rst_level", 256'(level), 256'h0);
        chk("mr_rst_therm", therm, 256'h1);
        chk("mr_rst_busy", 256'(busy), 256'h0);
        chk("mr_rst_ready", 256'(tgt_ready), 256'h1);
        tick();
        chk("mr_rst_done", 256'(done), 256'h0);
        #2 rst = 1'b0;
        do_ramp("mr_to2", 8'd2, 8'd0, 2);
        tick();

        // Full scale, second request issued in the done cycle
        do_ramp("fs_to0", 8'd0, 8'd0, 2);
        tick();
        do_ramp("fs_up", 8'd255, 8'd0, 255);
        chk("fs_up_therm", therm, '1);
        do_ramp("fs_dn", 8'd0, 8'd0, 255);
        chk("fs_dn_therm", therm, 256'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
